data_mem: RTL and testbench

Data-memory responder for the Y86 pipeline. It services the read/write requests issued by the memory stage and returns the loaded word on `valM_o`, which feeds the memory stage's `valM_i`. Storage is byte-addressed, little-endian, with 32-bit words. Unaligned accesses are split into two aligned word accesses by an internal FSM. While a request is in flight, the block holds the pipeline with `mem_stall`.

---
 rtl/data_mem.sv | 123 ++++++++++++
 tb/tb_data_mem.sv | 125 ++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// rtl/data_mem.sv - Y86 data memory responder with split unaligned access FSM
module data_mem #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] valM_o,
    output logic        mem_ack,
    output logic        mem_stall,
    output logic        dmem_error
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [AW+1:0]  addr_q;
    logic [31:0]    data_q;
    logic [31:0]    result_q;
    logic           rd_q;
    logic           wr_q;
    logic           err_q;

    logic           req;
    logic           req_err;
    logic [1:0]     off;
    logic [4:0]     sh_lo;
    logic [5:0]     sh_hi;
    logic [AW-1:0]  idx;
    logic [31:0]    rword;
    logic [31:0]    wdata;
    logic [3:0]     lane_we;

    logic [7:0]     lane_mem [4][DEPTH_WORDS];

    assign req = mem_read | mem_write;
    // No wrap-around: an unaligned access to the last word would need word DEPTH_WORDS.
    assign req_err = (mem_read & mem_write)
                   | (|mem_addr[31:AW+2])
                   | ((mem_addr[1:0] != 2'd0) & (&mem_addr[AW+1:2]));

    assign off   = addr_q[1:0];
    assign sh_lo = {off, 3'b000};
    assign sh_hi = 6'd32 - {1'b0, off, 3'b000};
    assign idx   = addr_q[AW+1:2] + AW'(state == ACC2);

    assign mem_ack    = (state == RESP);
    assign dmem_error = mem_ack & err_q;
    assign mem_stall  = req & ~mem_ack;

    always_comb begin
        rword   = '0;
        lane_we = '0;
        wdata   = (state == ACC2) ? (data_q >> sh_hi) : (data_q << sh_lo);
        for (int k = 0; k < 4; k++) begin
            rword[8*k +: 8] = lane_mem[k][idx];
            lane_we[k] = wr_q & (((state == ACC1) && (k >= int'(off))) ||
                                 ((state == ACC2) && (k <  int'(off))));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                lane_mem[k][idx] <= wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = req_err ? RESP : ACC1;
            ACC1: state_next = (off == 2'd0) ? RESP : ACC2;
            ACC2: state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            valM_o   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= mem_addr[AW+1:0];
                        data_q <= mem_data;
                        rd_q   <= mem_read;
                        wr_q   <= mem_write;
                        err_q  <= req_err;
                        if (mem_read && req_err) valM_o <= '0;
                    end
                end
                ACC1: begin
                    // valM_o is loaded on entry to RESP so it is valid in the ack cycle.
                    if (rd_q) begin
                        if (off == 2'd0) valM_o <= rword;
                        else             result_q <= rword >> sh_lo;
                    end
                end
                ACC2: begin
                    if (rd_q) valM_o <= result_q | (rword << sh_hi);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem
module tb_data_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] valM_o;
    logic        mem_ack;
    logic        mem_stall;
    logic        dmem_error;

    int passed = 0;
    int total  = 0;

    data_mem #(.DEPTH_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .valM_o     (valM_o),
        .mem_ack    (mem_ack),
        .mem_stall  (mem_stall),
        .dmem_error (dmem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic release_bus();
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Drives one request in cycle T, waits for ack, checks latency/error/value/stall.
    task automatic xfer(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_err,
                        input logic chk_val, input logic [31:0] exp_val,
                        input logic hold);
        int   lat;
        int   stalls;
        logic seen;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_addr = a; mem_data = d;
        lat = 0; stalls = 0; seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_ack) begin
                seen = 1'b1;
                lat  = n;
                break;
            end
            if (mem_stall) stalls++;
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
        check({tag, "_stall_at_ack"}, 32'(mem_stall), 32'd0);
        check({tag, "_error"}, 32'(dmem_error), 32'(exp_err));
        if (chk_val) check({tag, "_valM"}, valM_o, exp_val);
        if (!hold) release_bus();
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data = '0;
        @(negedge clk);
        check("reset_valM", valM_o, 32'h0);
        check("reset_ack", 32'(mem_ack), 32'd0);
        check("reset_error", 32'(dmem_error), 32'd0);
        check("reset_stall", 32'(mem_stall), 32'd0);
        rst = 1'b0;

        // aligned store/load
        xfer("wr_al",   0, 1, 32'h100, 32'h11223344, 2, 0, 1, 32'h00000000, 0);
        xfer("rd_al",   1, 0, 32'h100, 32'h0,        2, 0, 1, 32'h11223344, 0);
        // unaligned store spanning two words
        xfer("wr_104",  0, 1, 32'h104, 32'h55667788, 2, 0, 1, 32'h11223344, 0);
        xfer("wr_una",  0, 1, 32'h102, 32'hAABBCCDD, 3, 0, 1, 32'h11223344, 0);
        xfer("rd_100",  1, 0, 32'h100, 32'h0,        2, 0, 1, 32'hCCDD3344, 0);
        xfer("rd_104",  1, 0, 32'h104, 32'h0,        2, 0, 1, 32'h5566AABB, 0);
        xfer("rd_una",  1, 0, 32'h102, 32'h0,        3, 0, 1, 32'hAABBCCDD, 0);
        // range errors
        xfer("rd_oob",  1, 0, 32'h1000, 32'h0,       1, 1, 1, 32'h00000000, 0);
        xfer("wr_last", 0, 1, 32'hFFC, 32'h01020304, 2, 0, 1, 32'h00000000, 0);
        xfer("wr_wrap", 0, 1, 32'hFFE, 32'hDEADBEEF, 1, 1, 1, 32'h00000000, 0);
        xfer("rd_last", 1, 0, 32'hFFC, 32'h0,        2, 0, 1, 32'h01020304, 0);
        // read/write conflict
        xfer("conflict", 1, 1, 32'h100, 32'hFFFFFFFF, 1, 1, 0, 32'h0, 0);
        xfer("rd_after_conf", 1, 0, 32'h100, 32'h0,  2, 0, 1, 32'hCCDD3344, 0);
        // back-to-back: write then read with no gap
        xfer("b2b_pre", 1, 0, 32'h104, 32'h0,        2, 0, 1, 32'h5566AABB, 0);
        xfer("b2b_wr",  0, 1, 32'h108, 32'h12345678, 2, 0, 1, 32'h5566AABB, 1);
        xfer("b2b_rd",  1, 0, 32'h108, 32'h0,        2, 0, 1, 32'h12345678, 0);
        // reset during ACC2 of an unaligned write
        xfer("rs_w100", 0, 1, 32'h100, 32'h11223344, 2, 0, 1, 32'h12345678, 0);
        xfer("rs_w104", 0, 1, 32'h104, 32'h55667788, 2, 0, 1, 32'h12345678, 0);
        xfer("rs_r104", 1, 0, 32'h104, 32'h0,        2, 0, 1, 32'h55667788, 0);
        @(posedge clk); #1;
        mem_write = 1'b1; mem_addr = 32'h102; mem_data = 32'hAABBCCDD;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1; mem_write = 1'b0;
        #1;
        check("rst_mid_valM", valM_o, 32'h0);
        check("rst_mid_ack", 32'(mem_ack), 32'd0);
        check("rst_mid_error", 32'(dmem_error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xfer("rs_r100", 1, 0, 32'h100, 32'h0,        2, 0, 1, 32'hCCDD3344, 0);
        xfer("rs_r104b", 1, 0, 32'h104, 32'h0,       2, 0, 1, 32'h55667788, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
